// File: rtl/requisitante_operacao_if.sv
// Signal bundle between the batch requester (master), its loader/consumer and the operation unit (slave).
interface requisitante_operacao_if #(
    parameter int PROFUNDIDADE = 4
);
    localparam int IDX_W = $clog2(PROFUNDIDADE);

    logic             carregar;
    logic [7:0]       x_in;
    logic             disparar;
    logic [15:0]      a_in;
    logic [15:0]      b_in;
    logic [15:0]      c_in;
    logic             inicio;
    logic [7:0]       x;
    logic [15:0]      a;
    logic [15:0]      b;
    logic [15:0]      c;
    logic             comecou;
    logic             pronto;
    logic [15:0]      resultado;
    logic             res_valido;
    logic [15:0]      res_dado;
    logic [IDX_W-1:0] res_indice;
    logic             ocupado;
    logic             cheio;
    logic             vazio;
    logic             lote_fim;
    logic             erro;

    modport master (
        input  carregar, x_in, disparar, a_in, b_in, c_in, comecou, pronto, resultado,
        output inicio, x, a, b, c, res_valido, res_dado, res_indice,
        output ocupado, cheio, vazio, lote_fim, erro
    );

    modport slave (
        output carregar, x_in, disparar, a_in, b_in, c_in, comecou, pronto, resultado,
        input  inicio, x, a, b, c, res_valido, res_dado, res_indice,
        input  ocupado, cheio, vazio, lote_fim, erro
    );
endinterface

// File: rtl/requisitante_operacao.sv
// Queues X operands and drains them as one batch through an operation unit using a
// start/acknowledge/done handshake, with a bounded wait for the acknowledge.
module requisitante_operacao #(
    parameter int PROFUNDIDADE = 4,
    parameter int LIMITE       = 15
) (
    input logic                     clk,
    input logic                     rst,
    requisitante_operacao_if.master bus
);
    localparam int IDX_W = $clog2(PROFUNDIDADE);
    localparam int CNT_W = $clog2(LIMITE + 1);
    localparam logic [CNT_W-1:0] ULTIMA_ESPERA = CNT_W'(LIMITE - 1);
    localparam logic [IDX_W:0]   CAPACIDADE    = (IDX_W + 1)'(PROFUNDIDADE);

    typedef enum logic [1:0] {OCIOSO, ENVIA, ESPERA, ENTREGA} estado_t;

    estado_t          state_q, state_d;
    logic [7:0]       fila_q [PROFUNDIDADE];
    logic [IDX_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [IDX_W:0]   count_q, count_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic [7:0]       x_q, x_d;
    logic [15:0]      a_q, a_d, b_q, b_d, c_q, c_d;
    logic [15:0]      res_dado_q, res_dado_d;
    logic             erro_q, erro_d;
    logic             timeout_q, timeout_d;
    logic             lote_fim_q, lote_fim_d;
    logic             push, pop, cheio, vazio;

    assign cheio = (count_q == CAPACIDADE);
    assign vazio = (count_q == '0);
    assign push  = bus.carregar && !cheio;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        wait_d     = wait_q;
        x_d        = x_q;
        a_d        = a_q;
        b_d        = b_q;
        c_d        = c_q;
        res_dado_d = res_dado_q;
        erro_d     = erro_q;
        timeout_d  = 1'b0;
        lote_fim_d = 1'b0;
        pop        = 1'b0;

        case (state_q)
            OCIOSO: begin
                if (bus.disparar) begin
                    if (vazio) begin
                        lote_fim_d = 1'b1;
                    end else begin
                        a_d     = bus.a_in;
                        b_d     = bus.b_in;
                        c_d     = bus.c_in;
                        idx_d   = '0;
                        wait_d  = '0;
                        pop     = 1'b1;
                        x_d     = fila_q[rd_ptr_q];
                        state_d = ENVIA;
                    end
                end
            end
            ENVIA: begin
                if (bus.comecou) begin
                    state_d = ESPERA;
                end else if (wait_q == ULTIMA_ESPERA) begin
                    // Entry abandoned: ENTREGA still advances the index but stays silent.
                    erro_d    = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = ENTREGA;
                end else begin
                    wait_d = wait_q + CNT_W'(1);
                end
            end
            ESPERA: begin
                if (bus.pronto) begin
                    res_dado_d = bus.resultado;
                    state_d    = ENTREGA;
                end
            end
            ENTREGA: begin
                idx_d = idx_q + IDX_W'(1);
                if (!vazio) begin
                    pop     = 1'b1;
                    x_d     = fila_q[rd_ptr_q];
                    wait_d  = '0;
                    state_d = ENVIA;
                end else begin
                    lote_fim_d = 1'b1;
                    state_d    = OCIOSO;
                end
            end
            default: state_d = OCIOSO;
        endcase

        case ({push, pop})
            2'b10:   count_d = count_q + (IDX_W + 1)'(1);
            2'b01:   count_d = count_q - (IDX_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples the pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= OCIOSO;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            idx_q      <= '0;
            wait_q     <= '0;
            x_q        <= '0;
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= '0;
            res_dado_q <= '0;
            erro_q     <= 1'b0;
            timeout_q  <= 1'b0;
            lote_fim_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            wait_q     <= wait_d;
            x_q        <= x_d;
            a_q        <= a_d;
            b_q        <= b_d;
            c_q        <= c_d;
            res_dado_q <= res_dado_d;
            erro_q     <= erro_d;
            timeout_q  <= timeout_d;
            lote_fim_q <= lote_fim_d;
            if (push) wr_ptr_q <= wr_ptr_q + IDX_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + IDX_W'(1);
        end
    end

    // NOTE: queue storage is not reset; count_q and the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) fila_q[wr_ptr_q] <= bus.x_in;
    end

    assign bus.inicio     = (state_q == ENVIA);
    assign bus.ocupado    = (state_q != OCIOSO);
    assign bus.res_valido = (state_q == ENTREGA) && !timeout_q;
    assign bus.res_indice = idx_q;
    assign bus.res_dado   = res_dado_q;
    assign bus.x          = x_q;
    assign bus.a          = a_q;
    assign bus.b          = b_q;
    assign bus.c          = c_q;
    assign bus.cheio      = cheio;
    assign bus.vazio      = vazio;
    assign bus.lote_fim   = lote_fim_q;
    assign bus.erro       = erro_q;
endmodule

// File: tb/tb_requisitante_operacao.sv
// Self-checking bench: randomized batches against a queue-based model of the requester.
module tb_requisitante_operacao;
    localparam int DEPTH = 4;
    localparam int LIM   = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          n_checks = 0;
    int          n_pass = 0;
    logic [7:0]  q_model[$];
    logic [15:0] coef_a = '0, coef_b = '0, coef_c = '0;
    logic        exp_erro = 1'b0;

    requisitante_operacao_if #(.PROFUNDIDADE(DEPTH)) bus ();

    requisitante_operacao #(.PROFUNDIDADE(DEPTH), .LIMITE(LIM)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Operation unit behaviour: A*X^2 + B*X + C, truncated to 16 bits.
    function automatic logic [15:0] calc(input logic [7:0] xv);
        logic [15:0] xw;
        xw = {8'd0, xv};
        return coef_a * xw * xw + coef_b * xw + coef_c;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] v);
        bus.carregar = 1'b1;
        bus.x_in     = v;
        step();
        bus.carregar = 1'b0;
        if (q_model.size() < DEPTH) q_model.push_back(v);
    endtask

    task automatic start_batch(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        coef_a = a; coef_b = b; coef_c = c;
        bus.a_in = a; bus.b_in = b; bus.c_in = c;
        bus.disparar = 1'b1;
        step();
        bus.disparar = 1'b0;
        bus.a_in = 16'($urandom); bus.b_in = 16'($urandom); bus.c_in = 16'($urandom);
    endtask

    // Entered at the first ENVIA cycle of an entry; returns at its ENTREGA cycle.
    task automatic serve_entry(input logic [7:0] xe, input int idx, input int dc, input int dp,
                               input bit never, input bit early, input string tag);
        logic [15:0] r;
        int n;
        r = calc(xe);
        n_checks++; if (bus.inicio !== 1'b1) $display("FAIL %s_inicio_up idx=%0d got=%b exp=1", tag, idx, bus.inicio); else n_pass++;
        n_checks++; if (bus.x !== xe) $display("FAIL %s_x idx=%0d got=%0d exp=%0d", tag, idx, bus.x, xe); else n_pass++;
        n_checks++; if ({bus.a, bus.b, bus.c} !== {coef_a, coef_b, coef_c}) $display("FAIL %s_abc got=%h exp=%h", tag, {bus.a, bus.b, bus.c}, {coef_a, coef_b, coef_c}); else n_pass++;
        if (never) begin
            n = 0;
            while (bus.inicio === 1'b1 && n < 40) begin
                n++;
                step();
            end
            exp_erro = 1'b1;
            n_checks++; if (n != LIM) $display("FAIL %s_inicio_cycles got=%0d exp=%0d", tag, n, LIM); else n_pass++;
            n_checks++; if (bus.res_valido !== 1'b0) $display("FAIL %s_timeout_valid got=%b exp=0", tag, bus.res_valido); else n_pass++;
            n_checks++; if (bus.erro !== 1'b1) $display("FAIL %s_erro got=%b exp=1", tag, bus.erro); else n_pass++;
            return;
        end
        for (int k = 0; k < dc; k++) step();
        n_checks++; if (bus.inicio !== 1'b1 || bus.res_valido !== 1'b0) $display("FAIL %s_inicio_hold got=%b/%b exp=1/0", tag, bus.inicio, bus.res_valido); else n_pass++;
        bus.comecou = 1'b1;
        step();
        bus.comecou = 1'b0;
        n_checks++; if (bus.inicio !== 1'b0 || bus.ocupado !== 1'b1) $display("FAIL %s_espera got inicio=%b ocupado=%b exp 0/1", tag, bus.inicio, bus.ocupado); else n_pass++;
        n_checks++; if (bus.x !== xe || bus.a !== coef_a) $display("FAIL %s_stable got x=%0d a=%h exp x=%0d a=%h", tag, bus.x, bus.a, xe, coef_a); else n_pass++;
        if (early) begin
            n_checks++; if (bus.res_dado === 16'hDEAD) $display("FAIL %s_early_capture got=%h exp!=dead", tag, bus.res_dado); else n_pass++;
            bus.resultado = r;
            step();
            bus.pronto = 1'b0;
        end else begin
            for (int k = 0; k < dp; k++) step();
            n_checks++; if (bus.res_valido !== 1'b0) $display("FAIL %s_valid_early got=%b exp=0", tag, bus.res_valido); else n_pass++;
            bus.pronto    = 1'b1;
            bus.resultado = r;
            step();
            bus.pronto    = 1'b0;
            bus.resultado = 16'($urandom);
        end
        n_checks++; if (bus.res_valido !== 1'b1) $display("FAIL %s_valid idx=%0d got=%b exp=1", tag, idx, bus.res_valido); else n_pass++;
        n_checks++; if (bus.res_dado !== r) $display("FAIL %s_dado idx=%0d got=%h exp=%h", tag, idx, bus.res_dado, r); else n_pass++;
        n_checks++; if (bus.res_indice !== 2'(idx % DEPTH)) $display("FAIL %s_indice got=%0d exp=%0d", tag, bus.res_indice, idx % DEPTH); else n_pass++;
        n_checks++; if (bus.erro !== exp_erro) $display("FAIL %s_erro_level got=%b exp=%b", tag, bus.erro, exp_erro); else n_pass++;
    endtask

    // Entered at the cycle after the last ENTREGA.
    task automatic close_checks(input string tag);
        n_checks++; if (bus.lote_fim !== 1'b1) $display("FAIL %s_lote_fim got=%b exp=1", tag, bus.lote_fim); else n_pass++;
        n_checks++; if (bus.ocupado !== 1'b0 || bus.vazio !== 1'b1 || bus.inicio !== 1'b0) $display("FAIL %s_end_status got ocupado=%b vazio=%b inicio=%b exp 0/1/0", tag, bus.ocupado, bus.vazio, bus.inicio); else n_pass++;
        step();
        n_checks++; if (bus.lote_fim !== 1'b0) $display("FAIL %s_lote_fim_pulse got=%b exp=0", tag, bus.lote_fim); else n_pass++;
    endtask

    task automatic run_batch(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                             input int dc_fix, input int dp_fix, input int timeout_at, input string tag);
        int idx;
        logic [7:0] xe;
        start_batch(a, b, c);
        idx = 0;
        while (q_model.size() > 0 && idx < 32) begin
            xe = q_model.pop_front();
            serve_entry(xe, idx, (dc_fix < 0) ? int'($urandom_range(0, 4)) : dc_fix,
                        (dp_fix < 0) ? int'($urandom_range(0, 4)) : dp_fix, idx == timeout_at, 1'b0, tag);
            idx++;
            step();
        end
        close_checks(tag);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (bus.inicio !== 1'b0 || bus.ocupado !== 1'b0 || bus.res_valido !== 1'b0 || bus.lote_fim !== 1'b0 || bus.erro !== 1'b0) $display("FAIL reset_flags got %b%b%b%b%b exp 00000", bus.inicio, bus.ocupado, bus.res_valido, bus.lote_fim, bus.erro); else n_pass++;
        n_checks++; if (bus.vazio !== 1'b1 || bus.cheio !== 1'b0) $display("FAIL reset_queue got vazio=%b cheio=%b exp 1/0", bus.vazio, bus.cheio); else n_pass++;
        n_checks++; if ({bus.x, bus.a, bus.b, bus.c, bus.res_dado, bus.res_indice} !== '0) $display("FAIL reset_data got x=%0d a=%h dado=%h idx=%0d exp 0", bus.x, bus.a, bus.res_dado, bus.res_indice); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            n_checks++; if (bus.inicio !== 1'b0 || bus.ocupado !== 1'b0 || bus.vazio !== 1'b1 || bus.lote_fim !== 1'b0 || bus.res_dado !== 16'd0) $display("FAIL post_reset_quiet cycle=%0d got inicio=%b ocupado=%b vazio=%b lote_fim=%b", k, bus.inicio, bus.ocupado, bus.vazio, bus.lote_fim); else n_pass++;
        end
    endtask

    task automatic test_basic();
        load(8'd3);
        run_batch(16'd1, 16'd2, 16'd5, 2, 3, -1, "basic");
        n_checks++; if (bus.res_dado !== 16'd20) $display("FAIL basic_result got=%0d exp=20", bus.res_dado); else n_pass++;
    endtask

    task automatic test_empty();
        n_checks++; if (bus.vazio !== 1'b1) $display("FAIL empty_pre got vazio=%b exp=1", bus.vazio); else n_pass++;
        bus.disparar = 1'b1;
        step();
        bus.disparar = 1'b0;
        n_checks++; if (bus.lote_fim !== 1'b1) $display("FAIL empty_lote_fim got=%b exp=1", bus.lote_fim); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (bus.inicio !== 1'b0 || bus.ocupado !== 1'b0) $display("FAIL empty_idle cycle=%0d got inicio=%b ocupado=%b exp 0/0", k, bus.inicio, bus.ocupado); else n_pass++;
            step();
        end
        n_checks++; if (bus.lote_fim !== 1'b0) $display("FAIL empty_lote_fim_pulse got=%b exp=0", bus.lote_fim); else n_pass++;
    endtask

    task automatic test_full();
        for (int i = 1; i <= DEPTH; i++) load(8'(i));
        n_checks++; if (bus.cheio !== 1'b1 || bus.vazio !== 1'b0) $display("FAIL full_flags got cheio=%b vazio=%b exp 1/0", bus.cheio, bus.vazio); else n_pass++;
        load(8'd9);
        n_checks++; if (bus.cheio !== 1'b1) $display("FAIL full_ignore got cheio=%b exp=1", bus.cheio); else n_pass++;
        run_batch(16'($urandom), 16'($urandom), 16'($urandom), -1, -1, -1, "full");
    endtask

    task automatic test_random();
        int n;
        for (int b = 0; b < 5; b++) begin
            n = int'($urandom_range(1, DEPTH));
            for (int i = 0; i < n; i++) load(8'($urandom));
            run_batch(16'($urandom), 16'($urandom), 16'($urandom), -1, -1, -1, "random");
        end
    endtask

    task automatic test_pronto_early();
        logic [7:0] xe;
        bus.pronto    = 1'b1;
        bus.resultado = 16'hDEAD;
        xe = 8'($urandom);
        load(xe);
        start_batch(16'($urandom), 16'($urandom), 16'($urandom));
        xe = q_model.pop_front();
        serve_entry(xe, 0, 2, 0, 1'b0, 1'b1, "early");
        step();
        close_checks("early");
    endtask

    task automatic test_timeout();
        load(8'($urandom));
        load(8'($urandom));
        run_batch(16'($urandom), 16'($urandom), 16'($urandom), -1, -1, 0, "timeout");
        repeat (3) step();
        n_checks++; if (bus.erro !== 1'b1) $display("FAIL timeout_sticky got=%b exp=1", bus.erro); else n_pass++;
    endtask

    task automatic test_reset_mid_batch();
        logic [7:0] xe;
        for (int i = 0; i < 3; i++) load(8'($urandom));
        start_batch(16'($urandom), 16'($urandom), 16'($urandom));
        xe = q_model.pop_front();
        serve_entry(xe, 0, 1, 1, 1'b0, 1'b0, "mid");
        step();
        xe = q_model.pop_front();
        n_checks++; if (bus.inicio !== 1'b1 || bus.x !== xe) $display("FAIL mid_second got inicio=%b x=%0d exp 1/%0d", bus.inicio, bus.x, xe); else n_pass++;
        bus.comecou = 1'b1;
        step();
        bus.comecou = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        q_model.delete();
        exp_erro = 1'b0;
        n_checks++; if (bus.inicio !== 1'b0 || bus.ocupado !== 1'b0 || bus.vazio !== 1'b1 || bus.cheio !== 1'b0) $display("FAIL mid_reset_status got inicio=%b ocupado=%b vazio=%b cheio=%b exp 0/0/1/0", bus.inicio, bus.ocupado, bus.vazio, bus.cheio); else n_pass++;
        n_checks++; if (bus.erro !== 1'b0 || bus.lote_fim !== 1'b0 || bus.res_valido !== 1'b0) $display("FAIL mid_reset_flags got erro=%b lote_fim=%b valid=%b exp 0", bus.erro, bus.lote_fim, bus.res_valido); else n_pass++;
        n_checks++; if ({bus.x, bus.a, bus.b, bus.c, bus.res_dado, bus.res_indice} !== '0) $display("FAIL mid_reset_data got x=%0d a=%h dado=%h idx=%0d exp 0", bus.x, bus.a, bus.res_dado, bus.res_indice); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        bus.pronto    = 1'b1;
        bus.resultado = 16'h1234;
        for (int k = 0; k < 5; k++) begin
            step();
            n_checks++; if (bus.res_valido !== 1'b0 || bus.ocupado !== 1'b0 || bus.res_dado !== 16'd0) $display("FAIL mid_pronto_ignored cycle=%0d got valid=%b ocupado=%b dado=%h exp 0/0/0", k, bus.res_valido, bus.ocupado, bus.res_dado); else n_pass++;
        end
        bus.pronto = 1'b0;
    endtask

    initial begin
        bus.carregar = 1'b0; bus.x_in = '0; bus.disparar = 1'b0;
        bus.a_in = '0; bus.b_in = '0; bus.c_in = '0;
        bus.comecou = 1'b0; bus.pronto = 1'b0; bus.resultado = '0;
        test_reset();
        test_basic();
        test_empty();
        test_full();
        test_random();
        test_pronto_early();
        test_timeout();
        test_reset_mid_batch();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete, passed=%0d total=%0d", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end
endmodule
